// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch slice.
//   fetch_state_t     fetch sequencer states
//   DEFAULT_RESET_PC  default first fetch address
//   NOP_INST          canonical RV32I NOP (addi x0, x0, 0)
//   branch_target()   redirect target: base + (imm << 1), wrap-around
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // B-type immediates arrive unshifted; carry out of bit 31 is dropped.
  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [31:0] imm);
    return base + (imm << 1);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_buffer.sv
// fetch_buffer: BUF_DEPTH-entry FIFO of {pc, inst} pairs toward decode.
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_pc/inst  write an entry (ignored when full)
//   pop                 remove head entry (ignored when empty)
//   flush               empty the FIFO; overrides push and pop
//   full, empty, count  occupancy
//   head_pc, head_inst  head entry; holds its last value while empty
module fetch_buffer #(
  parameter  int unsigned BUF_DEPTH = 2,
  localparam int unsigned AW        = $clog2(BUF_DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_inst,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst
);

  logic [63:0]   mem [BUF_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign {head_pc, head_inst} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (flush) begin
      // Collapse onto the read pointer so the head outputs do not move.
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_pc, push_inst};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: RV32I fetch stage. Owns the PC, issues one word read at a
// time to instruction memory, buffers {pc, inst} toward decode, and applies
// taken-branch redirects (target = redir_base + (redir_imm << 1)).
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req/addr/gnt             fetch request handshake
//   imem_rvalid/rdata             in-order read response
//   dec_valid/ready/inst/pc       decode-side head of buffer
//   redir_valid/base/imm          taken branch from decode / immgen
//   misalign                      sticky misaligned-target flag
// Build option INST_FETCH_MISALIGN_TRAP_EN: a misaligned redirect target sets
// misalign and halts fetch until reset. Otherwise target[1:0] is cleared and
// misalign is tied low.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_base,
  input  logic [31:0] redir_imm,
  output logic        misalign
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   issued_q, issued_d;
  logic [31:0]   target;
  logic          accepted;
  logic          outstanding;
  logic          buf_push;
  logic          buf_flush;
  logic          buf_full;
  logic          buf_empty;
  logic [CW-1:0] buf_count;

`ifdef INST_FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic tgt_bad;

  assign target   = branch_target(redir_base, redir_imm);
  assign tgt_bad  = |target[1:0];
  assign misalign = misalign_q;
`else
  assign target   = branch_target(redir_base, redir_imm) & ~32'h3;
  assign misalign = 1'b0;
`endif

  // Request uses registered occupancy only: a same-cycle pop frees nothing.
  assign imem_req  = (state_q == RUN) && !buf_full;
  assign imem_addr = pc_q;
  assign accepted  = imem_req & imem_gnt;
  assign dec_valid = !buf_empty && (state_q != HALT);

  // A read is still in flight after this edge unless its data arrives now.
  assign outstanding = accepted ||
                       (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    issued_d  = issued_q;
    buf_push  = 1'b0;
    buf_flush = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (accepted) begin
          issued_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          buf_push = 1'b1;
          state_d  = RUN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
`ifdef INST_FETCH_MISALIGN_TRAP_EN
          state_d = misalign_q ? HALT : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    // Redirect overrides the normal push/increment decided above; any read
    // still in flight is retired through DRAIN so its data never lands.
    if (redir_valid && (state_q != HALT)) begin
      buf_flush = 1'b1;
      buf_push  = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
      if (tgt_bad) begin
        misalign_d = 1'b1;
        pc_d       = pc_q;
        state_d    = outstanding ? DRAIN : HALT;
      end else begin
        pc_d    = target;
        state_d = outstanding ? DRAIN : RUN;
      end
`else
      pc_d    = target;
      state_d = outstanding ? DRAIN : RUN;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      issued_q <= '0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (buf_push),
    .push_pc  (issued_q),
    .push_inst(imem_rdata),
    .pop      (dec_valid & dec_ready),
    .flush    (buf_flush),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count),
    .head_pc  (dec_pc),
    .head_inst(dec_inst)
  );

  occupancy_ok: assert property (@(posedge clk) disable iff (!rst_n)
    (buf_count <= CW'(BUF_DEPTH)) && (buf_full == (buf_count == CW'(BUF_DEPTH))));

endmodule
